pdp_wdma_pack: RTL and testbench
================================

Name: pdp_wdma_pack

Overview:
Downstream neighbour of the PDP core. Consumes the 8-bit pooled-element stream (pdp_dp2wdma_*) and packs 8 consecutive elements (one 8-channel atom) into a 64-bit DMA write beat. Generates the destination address for each beat from cube counters and strides, and pulses dp2reg_done once the last beat of the cube has been accepted by the DMA write port.

Parameters:
ATOM_BYTES, 8, elements per atom / bytes per beat; fixed, not overridable in this release
AW, 32, DMA address width

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rstn  in  1  reset, asynchronous, active-low
reg2dp_op_en  in  1  level; starts a layer when high in IDLE
reg2dp_dst_base_addr  in  AW  cube base byte address, 8-byte aligned
reg2dp_dst_line_stride  in  AW  bytes between output lines
reg2dp_dst_surface_stride  in  AW  bytes between channel surfaces
reg2dp_cube_out_width  in  13  output width minus 1
reg2dp_cube_out_height  in  13  output height minus 1
reg2dp_cube_out_channel  in  13  output channels minus 1; surfaces = channel[12:3]+1
pdp_dp2wdma_pd  in  8  pooled element
pdp_dp2wdma_valid  in  1  element valid
pdp_dp2wdma_ready  out  1  element accepted when valid&ready
dma_wr_req_addr  out  AW  beat address
dma_wr_req_data  out  64  beat data; element k in bits [8k+7:8k]
dma_wr_req_valid  out  1  beat valid
dma_wr_req_ready  in  1  beat accepted when valid&ready
dp2reg_done  out  1  single-cycle layer-done pulse

Behaviour:
- Reset values: pdp_dp2wdma_ready=0, dma_wr_req_valid=0, addr=0, data=0, dp2reg_done=0; all counters and FSM cleared. Reset mid-layer aborts; no done pulse.
- FSM: IDLE -> RUN when reg2dp_op_en=1 (config sampled this cycle into shadow registers; register values may change afterward without effect). RUN -> DRAIN when the last element of the cube is accepted. DRAIN -> DONE when the final beat handshakes. DONE -> IDLE after one cycle; dp2reg_done=1 only in DONE.
- Element order: channel-within-atom fastest, then w, then h, then surface.
- Packing: byte_cnt 0..7; accepted element written to lane byte_cnt of the accumulator. On acceptance with byte_cnt=7, the full 64-bit word plus the current address loads the output register (valid=1), and byte_cnt wraps to 0.
- Input ready: RUN & (byte_cnt!=7 | !dma_wr_req_valid | dma_wr_req_ready). Elements 0..6 of an atom are never stalled by output backpressure. Load and drain in the same cycle is permitted, giving zero bubbles at full rate.
- Output register holds addr/data stable while valid & !ready.
- Addressing without multipliers:
  - addr = surf_base + line_base_off + w_cnt*8, maintained additively.
  - Per beat: w_off += 8.
  - At w_cnt = width: w resets, line_base += line_stride.
  - At h_cnt = height: line resets, surf_base += surface_stride.
  - All sums are modulo 2^AW.
  - First beat address = dst_base_addr.
- Last-element detect: byte_cnt=7 & w=width & h=height & surf=last.
- Throughput: 1 element/cycle in; 1 beat per 8 cycles out.
- Latency: the beat is valid the cycle after its 8th element is accepted.
- reg2dp_op_en held high in DONE does not retrigger until FSM reaches IDLE; the next layer can start on the cycle after DONE.

Decomposition:
- Shared package pdp_wdma_pkg: ATOM_BYTES, FSM state encoding (IDLE/RUN/DRAIN/DONE), 64-bit beat struct {addr, data}.
- One natural sub-module, pdp_wdma_addr_gen: w/h/surface counters and additive address registers, advanced by a beat_load strobe, with a last_beat output.

Test Plan:
- width=0, height=0, channel=7, base=0x1000: 8 elements 0x01..0x08 -> one beat, addr 0x1000, data 0x0807060504030201; done pulse the cycle after the beat handshake.
- width=1, height=1, channel=15, line_stride=0x40, surface_stride=0x200, base=0: beats at 0x0, 0x8, 0x40, 0x48, 0x200, 0x208, 0x240, 0x248; exactly one done pulse.
- dma_wr_req_ready=0 for 20 cycles mid-stream: input stalls only when byte_cnt=7 with the output full; addr/data stable throughout; no element lost or duplicated (scoreboard).
- Continuous valid with ready=1: 64 elements -> 8 beats in 64+1 cycles; no input bubble.
- base=0xFFFFFFF8, width=1: second beat addr wraps to 0x00000000.
- Assert reset after 3 beats of a 4-beat layer: all outputs 0 and no done pulse. Re-run the same config from op_en: 4 correct beats and one done pulse.

Source files
------------

// File: rtl/pdp_wdma_pkg.sv
// pdp_wdma_pkg: shared constants, FSM encoding and beat type for the PDP write-DMA packer
package pdp_wdma_pkg;
  localparam int ATOM_BYTES = 8;
  localparam int AW = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    logic [AW-1:0]           addr;
    logic [8*ATOM_BYTES-1:0] data;
  } beat_t;
endpackage

// File: rtl/pdp_wdma_addr_gen.sv
// pdp_wdma_addr_gen: cube w/h/surface counters and additive beat address, stepped once per packed beat
module pdp_wdma_addr_gen
  import pdp_wdma_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          start,
  input  logic          beat_load,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] line_stride,
  input  logic [AW-1:0] surface_stride,
  input  logic [12:0]   width,
  input  logic [12:0]   height,
  input  logic [9:0]    surf_last,
  output logic [AW-1:0] addr,
  output logic          last_beat
);
  logic [AW-1:0] ls_q, ls_d, ss_q, ss_d;
  logic [AW-1:0] surf_base_q, surf_base_d, line_base_q, line_base_d, addr_q, addr_d;
  logic [12:0]   width_q, width_d, height_q, height_d, w_cnt_q, w_cnt_d, h_cnt_q, h_cnt_d;
  logic [9:0]    surf_last_q, surf_last_d, s_cnt_q, s_cnt_d;
  logic          w_end, h_end;
  assign w_end     = w_cnt_q == width_q;
  assign h_end     = h_cnt_q == height_q;
  assign last_beat = w_end & h_end & (s_cnt_q == surf_last_q);
  assign addr      = addr_q;
  // Shadow the config on start; on each beat step w, then the line, then the surface using adds only
  always_comb begin
    ls_d        = ls_q;
    ss_d        = ss_q;
    width_d     = width_q;
    height_d    = height_q;
    surf_last_d = surf_last_q;
    w_cnt_d     = w_cnt_q;
    h_cnt_d     = h_cnt_q;
    s_cnt_d     = s_cnt_q;
    surf_base_d = surf_base_q;
    line_base_d = line_base_q;
    addr_d      = addr_q;
    if (start) begin
      ls_d        = line_stride;
      ss_d        = surface_stride;
      width_d     = width;
      height_d    = height;
      surf_last_d = surf_last;
      w_cnt_d     = '0;
      h_cnt_d     = '0;
      s_cnt_d     = '0;
      surf_base_d = base_addr;
      line_base_d = base_addr;
      addr_d      = base_addr;
    end else if (beat_load) begin
      if (!w_end) begin
        w_cnt_d = w_cnt_q + 13'd1;
        addr_d  = addr_q + AW'(ATOM_BYTES);
      end else if (!h_end) begin
        w_cnt_d     = '0;
        h_cnt_d     = h_cnt_q + 13'd1;
        line_base_d = line_base_q + ls_q;
        addr_d      = line_base_d;
      end else begin
        w_cnt_d     = '0;
        h_cnt_d     = '0;
        s_cnt_d     = s_cnt_q + 10'd1;
        surf_base_d = surf_base_q + ss_q;
        line_base_d = surf_base_d;
        addr_d      = surf_base_d;
      end
    end
  end
  // Counter and address state
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ls_q        <= '0;
      ss_q        <= '0;
      width_q     <= '0;
      height_q    <= '0;
      surf_last_q <= '0;
      w_cnt_q     <= '0;
      h_cnt_q     <= '0;
      s_cnt_q     <= '0;
      surf_base_q <= '0;
      line_base_q <= '0;
      addr_q      <= '0;
    end else begin
      ls_q        <= ls_d;
      ss_q        <= ss_d;
      width_q     <= width_d;
      height_q    <= height_d;
      surf_last_q <= surf_last_d;
      w_cnt_q     <= w_cnt_d;
      h_cnt_q     <= h_cnt_d;
      s_cnt_q     <= s_cnt_d;
      surf_base_q <= surf_base_d;
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
    end
  end
endmodule

// File: rtl/pdp_wdma_pack.sv
// pdp_wdma_pack: packs 8 pooled bytes per atom into 64-bit DMA write beats and signals layer done
module pdp_wdma_pack
  import pdp_wdma_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          reg2dp_op_en,
  input  logic [AW-1:0] reg2dp_dst_base_addr,
  input  logic [AW-1:0] reg2dp_dst_line_stride,
  input  logic [AW-1:0] reg2dp_dst_surface_stride,
  input  logic [12:0]   reg2dp_cube_out_width,
  input  logic [12:0]   reg2dp_cube_out_height,
  input  logic [12:0]   reg2dp_cube_out_channel,
  input  logic [7:0]    pdp_dp2wdma_pd,
  input  logic          pdp_dp2wdma_valid,
  output logic          pdp_dp2wdma_ready,
  output logic [AW-1:0] dma_wr_req_addr,
  output logic [63:0]   dma_wr_req_data,
  output logic          dma_wr_req_valid,
  input  logic          dma_wr_req_ready,
  output logic          dp2reg_done
);
  state_e        state_q, state_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [63:0]   acc_q, acc_d;
  beat_t         out_q, out_d;
  logic          valid_q, valid_d;
  logic          start, accept, beat_load, last_beat, unused_ch;
  logic [AW-1:0] beat_addr;
  assign unused_ch         = ^reg2dp_cube_out_channel[2:0];
  assign start             = (state_q == IDLE) & reg2dp_op_en;
  assign pdp_dp2wdma_ready = (state_q == RUN) & ((byte_cnt_q != 3'd7) | !valid_q | dma_wr_req_ready);
  assign accept            = pdp_dp2wdma_valid & pdp_dp2wdma_ready;
  assign beat_load         = accept & (byte_cnt_q == 3'd7);
  assign dma_wr_req_addr   = out_q.addr;
  assign dma_wr_req_data   = out_q.data;
  assign dma_wr_req_valid  = valid_q;
  assign dp2reg_done       = state_q == DONE;
  pdp_wdma_addr_gen u_addr_gen (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .start          (start),
    .beat_load      (beat_load),
    .base_addr      (reg2dp_dst_base_addr),
    .line_stride    (reg2dp_dst_line_stride),
    .surface_stride (reg2dp_dst_surface_stride),
    .width          (reg2dp_cube_out_width),
    .height         (reg2dp_cube_out_height),
    .surf_last      (reg2dp_cube_out_channel[12:3]),
    .addr           (beat_addr),
    .last_beat      (last_beat)
  );
  // Layer sequencing: run until the last element, drain the final beat, then pulse done for one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = reg2dp_op_en ? RUN : IDLE;
      RUN:     state_d = (beat_load & last_beat) ? DRAIN : RUN;
      DRAIN:   state_d = (valid_q & dma_wr_req_ready) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // Byte-lane packing; the 8th byte goes straight into the output beat so a full beat never waits in acc
  always_comb begin
    byte_cnt_d = accept ? byte_cnt_q + 3'd1 : byte_cnt_q;
    acc_d      = acc_q;
    if (accept) acc_d[{byte_cnt_q, 3'b000} +: 8] = pdp_dp2wdma_pd;
    valid_d    = beat_load | (valid_q & !dma_wr_req_ready);
    out_d      = beat_load ? {beat_addr, acc_d} : out_q;
  end
  // State, packing and output registers
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end
endmodule

// File: tb/tb_pdp_wdma_pack.sv
// tb_pdp_wdma_pack: directed and random layers checked against an arithmetic model of the packed cube
module tb_pdp_wdma_pack;
  logic        clk, rstn, op_en;
  logic [31:0] base, ls, ss;
  logic [12:0] wd, ht, ch;
  logic [7:0]  pd;
  logic        in_valid, in_ready;
  logic [31:0] addr;
  logic [63:0] data;
  logic        out_valid, out_ready, done;
  int          errors = 0, checks = 0;
  int          cyc = 0, done_cnt, done_cyc, hs_cyc, acc_cnt, first_acc, last_acc;
  logic        in_layer = 0, prev_stall = 0;
  logic [95:0] prev_beat;
  logic [95:0] got[$];

  pdp_wdma_pack dut (
    .nvdla_core_clk           (clk),
    .nvdla_core_rstn          (rstn),
    .reg2dp_op_en             (op_en),
    .reg2dp_dst_base_addr     (base),
    .reg2dp_dst_line_stride   (ls),
    .reg2dp_dst_surface_stride(ss),
    .reg2dp_cube_out_width    (wd),
    .reg2dp_cube_out_height   (ht),
    .reg2dp_cube_out_channel  (ch),
    .pdp_dp2wdma_pd           (pd),
    .pdp_dp2wdma_valid        (in_valid),
    .pdp_dp2wdma_ready        (in_ready),
    .dma_wr_req_addr          (addr),
    .dma_wr_req_data          (data),
    .dma_wr_req_valid         (out_valid),
    .dma_wr_req_ready         (out_ready),
    .dp2reg_done              (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) prev_stall = 0;
      else begin
        if (prev_stall) chk("hold", {out_valid, addr, data}, {1'b1, prev_beat});
        prev_stall = out_valid && !out_ready;
        prev_beat  = {addr, data};
        if (in_layer && in_valid)
          chk("ready_rule", in_ready, (acc_cnt % 8 != 7) || !out_valid || out_ready);
        if (out_valid && out_ready) begin
          got.push_back({addr, data});
          hs_cyc = cyc;
        end
        if (in_valid && in_ready) begin
          if (first_acc < 0) first_acc = cyc;
          last_acc = cyc;
          acc_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_layer(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s,
                           input int w, input int h, input int c, input bit seq,
                           input int stall_at, input int stall_len, input bit gaps, input bit bp,
                           input int abort_beats);
    logic [7:0]  el[$];
    logic [95:0] exp_q[$];
    logic [63:0] d;
    logic [7:0]  v;
    int nb, n, idx, t;
    for (int sf = 0; sf <= c / 8; sf++)
      for (int hh = 0; hh <= h; hh++)
        for (int ww = 0; ww <= w; ww++) begin
          for (int k = 0; k < 8; k++) begin
            v = seq ? 8'(el.size() + 1) : 8'($urandom);
            el.push_back(v);
            d[8*k +: 8] = v;
          end
          exp_q.push_back({b + 32'(sf) * s + 32'(hh) * l + 32'(ww) * 8, d});
        end
    nb = exp_q.size();
    n  = el.size();
    got.delete();
    done_cnt = 0; acc_cnt = 0; first_acc = -1; last_acc = -1; hs_cyc = -1; done_cyc = -1;
    base = b; ls = l; ss = s; wd = 13'(w); ht = 13'(h); ch = 13'(c);
    op_en = 1;
    @(posedge clk); #1;
    op_en = 0;
    base = $urandom; ls = $urandom; ss = $urandom; wd = 13'($urandom); ht = 13'($urandom); ch = 13'($urandom);
    in_layer = 1;
    idx = 0; t = 0;
    while (done_cnt == 0 && t < 3000 && !(abort_beats > 0 && got.size() >= abort_beats)) begin
      in_valid  = idx < n && (!gaps || $urandom_range(3) != 0);
      pd        = in_valid ? el[idx] : 8'($urandom);
      out_ready = !(t >= stall_at && t < stall_at + stall_len) && (!bp || $urandom_range(1) == 1);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      t++;
    end
    in_layer = 0;
    in_valid = 0;
    if (t >= 3000) chk("timeout", 1, 0);
    if (abort_beats > 0) begin
      rstn = 0;
      @(negedge clk);
      chk("abort_outputs", {in_ready, out_valid, addr, data, done}, 0);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_beats", got.size(), abort_beats);
      for (int i = 0; i < got.size() && i < nb; i++) chk("abort_beat", got[i], exp_q[i]);
      @(posedge clk); #1;
      rstn = 1;
    end else begin
      out_ready = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("nbeats", got.size(), nb);
      for (int i = 0; i < got.size() && i < nb; i++) begin
        chk("beat_addr", got[i][95:64], exp_q[i][95:64]);
        chk("beat_data", got[i][63:0], exp_q[i][63:0]);
      end
      chk("done_count", done_cnt, 1);
      chk("done_timing", done_cyc, hs_cyc + 1);
      chk("elements", acc_cnt, n);
    end
  endtask

  initial begin
    logic [31:0] exp_addr[8];
    clk = 0; rstn = 0; op_en = 0; in_valid = 0; out_ready = 0; pd = 0;
    base = 0; ls = 0; ss = 0; wd = 0; ht = 0; ch = 0;
    exp_addr = '{32'h0, 32'h8, 32'h40, 32'h48, 32'h200, 32'h208, 32'h240, 32'h248};
    repeat (2) @(negedge clk);
    chk("reset_outputs", {in_ready, out_valid, addr, data, done}, 0);
    @(posedge clk); #1;
    rstn = 1;
    run_layer(32'h1000, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0);
    if (got.size() > 0) chk("single_beat", got[0], {32'h1000, 64'h0807060504030201});
    run_layer(32'h0, 32'h40, 32'h200, 1, 1, 15, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < got.size() && i < 8; i++) chk("stride_addr", got[i][95:64], exp_addr[i]);
    run_layer(32'h2000, 32'h100, 32'h1000, 3, 1, 15, 0, 12, 20, 0, 0, 0);
    run_layer(32'h3000, 32'h40, 32'h400, 7, 0, 7, 0, 0, 0, 0, 0, 0);
    chk("no_bubble", last_acc - first_acc, 63);
    chk("throughput", hs_cyc - first_acc, 64);
    run_layer(32'hFFFF_FFF8, 32'h40, 32'h200, 1, 0, 7, 0, 0, 0, 0, 0, 0);
    if (got.size() > 1) chk("wrap_addr", got[1][95:64], 32'h0);
    for (int r = 0; r < 4; r++)
      run_layer({$urandom_range(32'hFFFF), 3'b000}, {$urandom_range(32'hFFF), 3'b000},
                {$urandom_range(32'hFFFF), 3'b000}, $urandom_range(3), $urandom_range(2),
                $urandom_range(23), 0, 0, 0, 1, 1, 0);
    run_layer(32'h4000, 32'h40, 32'h200, 3, 0, 7, 0, 0, 0, 0, 0, 3);
    run_layer(32'h4000, 32'h40, 32'h200, 3, 0, 7, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
